// File: rtl/ones_pattern_gen_pkg.sv
// rtl/ones_pattern_gen_pkg.sv - shared types and helpers for the ones-pattern generator
package ones_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

  // Width needed to hold a ones-count of 0..n.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // k ones packed against the MSB of an n-bit word: the largest n-bit value with popcount k.
  function automatic int lastpat(input int k, input int n);
    return ((1 << k) - 1) << (n - k);
  endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// rtl/ones_pattern_gen_if.sv - start/output handshake bundle for ones_pattern_gen
interface ones_pattern_gen_if import ones_pkg::*; #(
  parameter int N  = 3,
  parameter int CW = cw_of(N)
) ();

  logic          start_valid;
  logic          start_ready;
  logic [CW-1:0] count_in;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_word;
  logic          out_last;
  logic          done;
  logic          err;

  modport master (
    output start_valid, count_in, out_ready,
    input  start_ready, out_valid, out_word, out_last, done, err
  );

  modport slave (
    input  start_valid, count_in, out_ready,
    output start_ready, out_valid, out_word, out_last, done, err
  );

endinterface

// File: rtl/ones_pattern_gen_fa.sv
// rtl/ones_pattern_gen_fa.sv - full-adder cell, three inputs to {carry, sum}
module ones_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ones_pattern_gen_popcount.sv
// rtl/ones_pattern_gen_popcount.sv - combinational popcount as a recursive tree of full adders
module popcount_n import ones_pkg::*; #(
  parameter int N  = 3,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  if (N == 1) begin : g_one
    assign count = bits;
  end else if (N == 2) begin : g_two
    ones_fa u_fa (.a(bits[0]), .b(bits[1]), .ci(1'b0), .s(count[0]), .co(count[1]));
  end else if (N == 3) begin : g_three
    ones_fa u_fa (.a(bits[0]), .b(bits[1]), .ci(bits[2]), .s(count[0]), .co(count[1]));
  end else begin : g_split
    localparam int NL  = N / 2;
    localparam int NH  = N - NL;
    localparam int CWL = cw_of(NL);
    localparam int CWH = cw_of(NH);

    logic [CWL-1:0] cnt_lo;
    logic [CWH-1:0] cnt_hi;
    logic [CW-1:0]  op_a;
    logic [CW-1:0]  op_b;
    logic [CW-1:0]  carry;

    popcount_n #(.N(NL)) u_lo (.bits(bits[NL-1:0]), .count(cnt_lo));
    popcount_n #(.N(NH)) u_hi (.bits(bits[N-1:NL]), .count(cnt_hi));

    assign op_a     = CW'(cnt_lo);
    assign op_b     = CW'(cnt_hi);
    assign carry[0] = 1'b0;

    // Ripple-add the two half counts; the sum never exceeds N so the top carry-out is not needed.
    for (genvar i = 0; i < CW - 1; i++) begin : g_rip
      ones_fa u_fa (.a(op_a[i]), .b(op_b[i]), .ci(carry[i]), .s(count[i]), .co(carry[i+1]));
    end
    assign count[CW-1] = op_a[CW-1] ^ op_b[CW-1] ^ carry[CW-1];
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - enumerates every N-bit word with exactly K ones in ascending order
module ones_pattern_gen import ones_pkg::*; #(
  parameter int N  = 3,
  parameter int CW = cw_of(N)
) (
  input logic              clk,
  input logic              rst_n,
  ones_pattern_gen_if.slave bus
);

  state_t        state_q, state_d;
  logic [N:0]    cand_q, cand_d;
  logic [CW-1:0] k_reg_q, k_reg_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_word_q, out_word_d;
  logic          out_last_q, out_last_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [CW-1:0] cand_ones;
  logic [31:0]   last_pat;
  logic          cand_match;
  logic          cand_is_last;
  logic          k_too_big;
  logic          start_hs;
  logic          xfer;

  popcount_n #(.N(N)) u_pop (.bits(cand_q[N-1:0]), .count(cand_ones));

  assign last_pat     = lastpat(int'(k_reg_q), N);
  assign cand_match   = (cand_ones == k_reg_q);
  assign cand_is_last = (32'(cand_q) == last_pat);
  assign k_too_big    = (bus.count_in > CW'(N));
  // The IDLE cycle that carries the done pulse is not yet open for a new request.
  assign start_hs     = (state_q == IDLE) && !done_q && bus.start_valid;
  assign xfer         = out_valid_q && bus.out_ready;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      k_reg_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      k_reg_q     <= k_reg_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_hs) state_d = k_too_big ? FIN : SCAN;
      SCAN: if (cand_match) state_d = EMIT;
      EMIT: if (xfer) state_d = out_last_q ? FIN : SCAN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Candidate scan, output word capture and end-of-run pulses.
  always_comb begin
    cand_d      = cand_q;
    k_reg_d     = k_reg_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_last_d  = out_last_q;
    done_d      = (state_q == FIN);
    err_d       = (state_q == FIN) && (k_reg_q > CW'(N));
    case (state_q)
      IDLE: begin
        if (start_hs) begin
          k_reg_d = bus.count_in;
          cand_d  = '0;
        end
      end
      SCAN: begin
        if (cand_match) begin
          out_word_d  = cand_q[N-1:0];
          out_valid_d = 1'b1;
          out_last_d  = cand_is_last;
        end else begin
          cand_d = cand_q + (N+1)'(1);
        end
      end
      EMIT: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          if (!out_last_q) cand_d = cand_q + (N+1)'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE) && !done_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_word    = out_word_q;
  assign bus.out_last    = out_last_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
